axis_state_tx: RTL and testbench

- AXI-Stream transmitter that serializes a 5x5x64 Keccak state (1600 bits) into DATA_WIDTH-bit beats.
- Beat index is carried on TDEST, so the state can be shipped to the assembling AXIS register block at the far end of the link.
- Sits after the Keccak permutation core: it snapshots the state on start and streams it out under TVALID/TREADY flow control.
- It can truncate the stream to the digest length and can prefix a clear beat (TDEST=255).

---
 rtl/axis_state_tx.sv | 142 ++++++++++++++
 tb/tb_axis_state_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_state_tx.sv
// AXI-Stream transmitter: snapshots a 1600-bit Keccak state on start and streams it out
// as DATA_WIDTH-bit beats, beat index on TDEST, optional leading clear beat (TDEST=255).
`timescale 1ns/1ps

module axis_state_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_BEATS  = 1600 / DATA_WIDTH,
  parameter bit SEND_CLEAR = 1'b0
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       start,
  input  logic [0:4][0:4][63:0]      D_in,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      TDATA,
  output logic                       TVALID,
  input  logic                       TREADY,
  output logic                       TLAST,
  output logic [7:0]                 TDEST,
  output logic                       TID,
  output logic [1:0]                 dbg_state
);

  localparam int         MAX_BEATS  = 1600 / DATA_WIDTH;
  localparam logic [7:0] LAST_IDX   = 8'(OUT_BEATS - 1);
  localparam logic       FIRST_LAST = (OUT_BEATS == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                  state;
  logic [1599:0]           snap;
  logic [1599:0]           flat_in;
  logic [7:0]              cnt;
  logic [7:0]              next_cnt;
  logic [DATA_WIDTH-1:0]   next_data;

  assign dbg_state = state;

  // Lane [x][y] lands at flat bits 64*(5y+x) upward.
  always_comb begin
    flat_in = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        flat_in[64*(5*y+x) +: 64] = D_in[x][y];
      end
    end
  end

  assign next_cnt = cnt + 8'd1;

  // Beat that follows the current one; prepared ahead so TDATA stays registered.
  always_comb begin
    next_data = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (int'(next_cnt) == i) next_data = snap[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      snap   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      TDATA  <= '0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
      TDEST  <= '0;
      TID    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap   <= flat_in;
            cnt    <= '0;
            busy   <= 1'b1;
            TVALID <= 1'b1;
            if (SEND_CLEAR) begin
              state <= CLR;
              TDEST <= 8'hFF;
              TDATA <= '0;
              TLAST <= 1'b0;
              TID   <= 1'b0;
            end else begin
              state <= SEND;
              TDEST <= 8'd0;
              TDATA <= flat_in[DATA_WIDTH-1:0];
              TLAST <= FIRST_LAST;
              TID   <= FIRST_LAST;
            end
          end
        end

        CLR: begin
          if (TVALID && TREADY) begin
            state <= SEND;
            cnt   <= '0;
            TDEST <= 8'd0;
            TDATA <= snap[DATA_WIDTH-1:0];
            TLAST <= FIRST_LAST;
            TID   <= FIRST_LAST;
          end
        end

        SEND: begin
          if (TVALID && TREADY) begin
            if (TLAST) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              TVALID <= 1'b0;
              TLAST  <= 1'b0;
              TID    <= 1'b0;
            end else begin
              cnt   <= next_cnt;
              TDEST <= next_cnt;
              TDATA <= next_data;
              TLAST <= (next_cnt == LAST_IDX);
              TID   <= (next_cnt == LAST_IDX);
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          TVALID <= 1'b0;
          TLAST  <= 1'b0;
          TID    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_state_tx.sv
// Bench for axis_state_tx: a plain 100-beat instance and a 16-beat instance with clear beat,
// driven from one sequence of scenario tasks against an expected-beat queue.
`timescale 1ns/1ps

module tb_axis_state_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  start0, start1;
  logic                  tready;
  logic [0:4][0:4][63:0] d_in;

  logic        busy0, done0, tvalid0, tlast0, tid0;
  logic [15:0] tdata0;
  logic [7:0]  tdest0;
  logic [1:0]  dbg0;
  logic        busy1, done1, tvalid1, tlast1, tid1;
  logic [15:0] tdata1;
  logic [7:0]  tdest1;
  logic [1:0]  dbg1;

  axis_state_tx #(.DATA_WIDTH(16), .OUT_BEATS(100), .SEND_CLEAR(1'b0)) dut0 (
    .ACLK(clk), .ARESETn(rst_n), .start(start0), .D_in(d_in),
    .busy(busy0), .done(done0), .TDATA(tdata0), .TVALID(tvalid0), .TREADY(tready),
    .TLAST(tlast0), .TDEST(tdest0), .TID(tid0), .dbg_state(dbg0)
  );

  axis_state_tx #(.DATA_WIDTH(16), .OUT_BEATS(16), .SEND_CLEAR(1'b1)) dut1 (
    .ACLK(clk), .ARESETn(rst_n), .start(start1), .D_in(d_in),
    .busy(busy1), .done(done1), .TDATA(tdata1), .TVALID(tvalid1), .TREADY(tready),
    .TLAST(tlast1), .TDEST(tdest1), .TID(tid1), .dbg_state(dbg1)
  );

  int          sel;
  logic        m_busy, m_done, m_tvalid, m_tlast, m_tid;
  logic [15:0] m_tdata;
  logic [7:0]  m_tdest;

  always_comb begin
    m_busy   = (sel == 1) ? busy1   : busy0;
    m_done   = (sel == 1) ? done1   : done0;
    m_tvalid = (sel == 1) ? tvalid1 : tvalid0;
    m_tlast  = (sel == 1) ? tlast1  : tlast0;
    m_tid    = (sel == 1) ? tid1    : tid0;
    m_tdata  = (sel == 1) ? tdata1  : tdata0;
    m_tdest  = (sel == 1) ? tdest1  : tdest0;
  end

  // Expected beat = {tlast, tdest, tdata}
  logic [24:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] rx_data[256];
  logic [7:0]  rx_dest[256];

  function automatic logic [15:0] beat_of(input int i);
    int          lane;
    logic [63:0] l;
    lane = i / 4;
    l    = d_in[lane % 5][lane / 5];
    return l[16*(i % 4) +: 16];
  endfunction

  task automatic push_frame(input int s);
    int n;
    n = (s == 1) ? 16 : 100;
    if (s == 1) exp_q.push_back({1'b0, 8'd255, 16'd0});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(i), beat_of(i)});
  endtask

  task automatic randomize_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) d_in[x][y] = {$urandom, $urandom};
  endtask

  task automatic pattern_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) d_in[x][y] = {8{4'(x), 4'(y)}};
  endtask

  // One frame on instance s. rnd: random TREADY. disturb_at: after that many beats,
  // pulse start and scramble D_in. abort_at: after that many beats, pulse reset.
  task automatic drive_frame(input int s, input bit rnd, input int disturb_at, input int abort_at);
    int          beats, cycles, n_total;
    bit          last_seen, held, aborted;
    logic [24:0] held_v, got, exp_v;
    beats = 0; cycles = 0; last_seen = 0; held = 0; aborted = 0; held_v = '0;
    sel = s;
    push_frame(s);
    n_total = exp_q.size();
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL start_latency: tvalid=%b required 1", m_tvalid);
    end
    while (!last_seen && cycles < 2000) begin
      got = {m_tlast, m_tdest, m_tdata};
      start0 = 1'b0; start1 = 1'b0;
      if (held) begin
        n_checks++;
        if (got !== held_v) begin
          n_fail++; $display("FAIL stable: got %h required %h", got, held_v);
        end
        held = 0;
      end
      n_checks++;
      if (m_tvalid !== 1'b1 || m_busy !== 1'b1) begin
        n_fail++; $display("FAIL valid_busy: tvalid=%b busy=%b required 1/1", m_tvalid, m_busy);
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_beat: got %h with empty queue", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++; $display("FAIL beat %0d: got %h required %h", beats, got, exp_v);
          end
        end
        n_checks++;
        if (m_tid !== m_tlast) begin
          n_fail++; $display("FAIL tid: tid=%b required %b", m_tid, m_tlast);
        end
        rx_data[beats[7:0]] = m_tdata;
        rx_dest[beats[7:0]] = m_tdest;
        beats++;
        if (m_tlast) last_seen = 1;
        if (beats == disturb_at) begin
          if (s == 1) start1 = 1'b1; else start0 = 1'b1;
          randomize_state();
        end
      end else if (m_tvalid) begin
        held = 1; held_v = got;
      end
      @(negedge clk);
      cycles++;
      if (abort_at >= 0 && beats == abort_at && !last_seen) begin
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || m_busy !== 1'b0) begin
          n_fail++; $display("FAIL abort_async: tvalid=%b busy=%b required 0/0", m_tvalid, m_busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_done !== 1'b0 || m_tlast !== 1'b0) begin
          n_fail++; $display("FAIL abort_done: done=%b tlast=%b required 0/0", m_done, m_tlast);
        end
        rst_n = 1'b1;
        exp_q.delete();
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      n_checks++;
      if (!last_seen) begin
        n_fail++; $display("FAIL timeout: %0d beats after %0d cycles", beats, cycles);
      end
      n_checks++;
      if (m_done !== 1'b1 || m_tvalid !== 1'b0 || m_busy !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse: done=%b tvalid=%b busy=%b required 1/0/0", m_done, m_tvalid, m_busy);
      end
      @(negedge clk);
      n_checks++;
      if (m_done !== 1'b0) begin
        n_fail++; $display("FAIL done_width: done=%b required 0", m_done);
      end
      n_checks++;
      if (beats != n_total || exp_q.size() != 0) begin
        n_fail++; $display("FAIL beat_count: got %0d beats, %0d left, required %0d", beats, exp_q.size(), n_total);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; tready = 1'b0; sel = 0;
    pattern_state();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tvalid0, busy0, done0, tlast0, tid0, tdest0, tdata0, dbg0} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: outputs %b required all 0",
                         {tvalid0, busy0, done0, tlast0, tid0, tdest0, tdata0, dbg0});
    end
    n_checks++;
    if ({tvalid1, busy1, done1, tlast1, tid1, tdest1, tdata1, dbg1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: outputs %b required all 0",
                         {tvalid1, busy1, done1, tlast1, tid1, tdest1, tdata1, dbg1});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tvalid0, busy0, done0, tdest0, tvalid1, busy1, done1, tdest1} !== '0) begin
        n_fail++; $display("FAIL idle_cycle %0d: tvalid=%b%b busy=%b%b done=%b%b tdest=%h/%h required 0",
                           c, tvalid0, tvalid1, busy0, busy1, done0, done1, tdest0, tdest1);
      end
    end
  endtask

  task automatic test_full_frame();
    pattern_state();
    drive_frame(0, 1'b0, -1, -1);
    n_checks++;
    if (rx_data[4] !== 16'h1010 || rx_dest[4] !== 8'd4) begin
      n_fail++; $display("FAIL beat4: data=%h dest=%0d required 1010/4", rx_data[4], rx_dest[4]);
    end
    n_checks++;
    if (rx_dest[99] !== 8'd99) begin
      n_fail++; $display("FAIL last_dest: got %0d required 99", rx_dest[99]);
    end
  endtask

  task automatic test_backpressure();
    randomize_state();
    drive_frame(0, 1'b1, -1, -1);
  endtask

  task automatic test_send_clear();
    randomize_state();
    drive_frame(1, 1'b1, -1, -1);
    n_checks++;
    if (rx_dest[0] !== 8'd255 || rx_data[0] !== 16'd0) begin
      n_fail++; $display("FAIL clear_beat: dest=%0d data=%h required 255/0000", rx_dest[0], rx_data[0]);
    end
    n_checks++;
    if (rx_dest[16] !== 8'd15 || rx_data[16] !== d_in[3][0][63:48]) begin
      n_fail++; $display("FAIL clear_last: dest=%0d data=%h required 15/%h", rx_dest[16], rx_data[16], d_in[3][0][63:48]);
    end
  endtask

  task automatic test_midframe();
    randomize_state();
    drive_frame(0, 1'b1, 30, -1);
  endtask

  task automatic test_abort();
    randomize_state();
    drive_frame(0, 1'b0, -1, 50);
    @(negedge clk);
    randomize_state();
    drive_frame(0, 1'b0, -1, -1);
    n_checks++;
    if (rx_dest[0] !== 8'd0 || rx_data[0] !== d_in[0][0][15:0]) begin
      n_fail++; $display("FAIL restart: dest=%0d data=%h required 0/%h", rx_dest[0], rx_data[0], d_in[0][0][15:0]);
    end
  endtask

  task automatic test_back_to_back();
    int          frames, beats, cycles;
    bit          gap, lower;
    logic [24:0] got, exp_v;
    sel = 1; tready = 1'b1;
    frames = 0; beats = 0; cycles = 0; gap = 0; lower = 0;
    randomize_state();
    push_frame(1);
    start1 = 1'b1;
    @(negedge clk);
    while (frames < 2 && cycles < 300) begin
      if (lower) begin start1 = 1'b0; lower = 0; end
      got = {m_tlast, m_tdest, m_tdata};
      n_checks++;
      if (gap) begin
        if (m_done !== 1'b1 || m_tvalid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_gap: done=%b tvalid=%b required 1/0", m_done, m_tvalid);
        end
        gap = 0;
        if (frames == 1) begin push_frame(1); lower = 1; end
      end else if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got %h with empty queue", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++; $display("FAIL b2b_beat f%0d b%0d: got %h required %h", frames, beats, got, exp_v);
          end
        end
        beats++;
        if (frames == 0 && beats == 5) randomize_state();
        if (m_tlast) begin frames++; gap = 1; beats = 0; end
      end else begin
        n_fail++; $display("FAIL b2b_bubble: tvalid=%b required 1", m_tvalid);
      end
      @(negedge clk);
      cycles++;
    end
    start1 = 1'b0;
    n_checks++;
    if (frames != 2 || exp_q.size() != 0 || m_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end: frames=%0d left=%0d done=%b required 2/0/1", frames, exp_q.size(), m_done);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_send_clear();
    test_midframe();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
